// File: rtl/mat_operand_loader_if.sv
// mat_operand_loader_if: element stream in, packed A/B operand buses and frame status out.
// Revision: 1.0
`default_nettype none

interface mat_operand_loader_if;
  logic [11:0]  in_data;
  logic         in_valid;
  logic         in_first;
  logic         in_ready;
  logic [119:0] A;
  logic [95:0]  B;
  logic         operands_valid;
  logic         c_capture;
  logic         frame_err;

  modport master (
    output in_data, in_valid, in_first,
    input  in_ready, A, B, operands_valid, c_capture, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_first,
    output in_ready, A, B, operands_valid, c_capture, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/mat_operand_loader.sv
// mat_operand_loader: packs an 18-word element stream into the 5x2 A / 2x4 B multiplier buses.
// Optional macro MATLOAD_TRANSPOSE_B_EN: B stream arrives column-major. Revision: 1.0
`default_nettype none

module mat_operand_loader #(
  parameter int HOLD_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mat_operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);

  state_t       state, state_next;
  logic [4:0]   idx, idx_next;
  logic [2:0]   hold_cnt, hold_next;
  logic         err_next, frame_err_q;
  logic [119:0] a_q;
  logic [95:0]  b_q;

  logic         ready;
  logic         accept;
  logic         resync;
  logic         a_we;
  logic         b_we;
  logic [3:0]   a_slot;
  logic [2:0]   b_m;
  logic [2:0]   b_slot;

  assign ready  = (state != HOLD);
  assign accept = bus.in_valid && ready;
  assign resync = accept && bus.in_first && (idx != 5'd0);
  assign a_we   = accept && (resync || (idx < 5'd10));
  assign b_we   = accept && !resync && (idx >= 5'd10);
  assign a_slot = resync ? 4'd0 : idx[3:0];

  // Indices 10..17 map to stream offsets 0..7 through their low three bits.
  assign b_m = idx[2:0] - 3'd2;

`ifdef MATLOAD_TRANSPOSE_B_EN
  // Offset m is row m%2, column m/2; row-major slot = row*4 + col.
  assign b_slot = {b_m[0], b_m[2:1]};
`else
  assign b_slot = b_m;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      idx         <= 5'd0;
      hold_cnt    <= 3'd0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      hold_cnt    <= hold_next;
      frame_err_q <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    hold_next  = hold_cnt;
    err_next   = 1'b0;
    case (state)
      LOAD_A, LOAD_B: begin
        if (resync) begin
          state_next = LOAD_A;
          idx_next   = 5'd1;
          err_next   = 1'b1;
        end else if (accept) begin
          if (idx == 5'd17) begin
            state_next = HOLD;
            hold_next  = 3'd0;
          end else begin
            idx_next = idx + 5'd1;
            if (idx == 5'd9) begin
              state_next = LOAD_B;
            end
          end
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = LOAD_A;
          idx_next   = 5'd0;
          hold_next  = 3'd0;
        end else begin
          hold_next = hold_cnt + 3'd1;
        end
      end
      default: begin
        state_next = LOAD_A;
        idx_next   = 5'd0;
        hold_next  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (a_we && (a_slot == 4'(k))) begin
          a_q[119-12*k -: 12] <= bus.in_data;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (b_we && (b_slot == 3'(k))) begin
          b_q[95-12*k -: 12] <= bus.in_data;
        end
      end
    end
  end

  assign bus.in_ready       = ready;
  assign bus.A              = a_q;
  assign bus.B              = b_q;
  assign bus.operands_valid = (state == HOLD);
  assign bus.c_capture      = (state == HOLD) && (hold_cnt == HOLD_LAST);
  assign bus.frame_err      = frame_err_q;

endmodule

`default_nettype wire

// File: doc/mat_operand_loader.md
# mat_operand_loader

Upstream feeder for the 5x2-by-2x4 matrix multiplier. It accepts a serial stream of 12-bit matrix elements over a valid/ready handshake and packs them into the multiplier's 120-bit A bus and 96-bit B bus. It then holds both buses stable long enough for the multiplier pipeline to produce C, and flags the cycle in which C is valid. The multiplier has no handshake of its own, so this block owns all frame sequencing.

## Interface
Parameters:
- HOLD_CYCLES, default 3: cycles A/B stay frozen after a full frame. Legal range 1..7. 3 matches the multiplier's operand-to-C latency.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- in_data  input  12  matrix element, unsigned.
- in_valid  input  1  in_data valid.
- in_first  input  1  qualifies in_data as element 0 of a frame; sampled only with in_valid.
- in_ready  output  1  loader can accept a word.
- A  output  120  packed 5x2 matrix, row-major; element k at A[119-12k -: 12].
- B  output  96  packed 2x4 matrix, row-major; element k at B[95-12k -: 12].
- operands_valid  output  1  A/B complete and frozen.
- c_capture  output  1  one-cycle pulse; downstream C valid this cycle.
- frame_err  output  1  one-cycle pulse; frame resynchronised.

## Operation
- Frame: 18 words. Words 0..9 are A elements, row-major (a00,a01,a10,…,a41). Words 10..17 are B elements (b00..b03,b10..b13).
- Accept: in_valid && in_ready at a rising edge.
- States:
  - LOAD_A: word index 0..9.
  - LOAD_B: word index 10..17.
  - HOLD: hold counter runs 0..HOLD_CYCLES-1.
- Transitions:
  - LOAD_A goes to LOAD_B on accepting index 9.
  - LOAD_B goes to HOLD on accepting index 17.
  - HOLD goes to LOAD_A after its final cycle, with word index cleared.
- Each accepted word is written to its A/B slot on the accepting edge. Other slots are unchanged.
- Resync: an accepted word with in_first=1 while the word index ≠ 0 is stored as element 0. The index becomes 1, the state becomes LOAD_A, and frame_err pulses on the next cycle. An accepted word with in_first=1 at index 0 is normal.
- in_first is ignored at index 0 and in HOLD.
- Width: no arithmetic is performed on data. The word index is 5 bits and saturates at 17 internally. It never wraps.

## Timing
- Reset values:
  - A=0, B=0.
  - in_ready=1 (state LOAD_A, index 0).
  - operands_valid=0, c_capture=0, frame_err=0.
- in_ready is combinational from state: 1 in LOAD_A/LOAD_B, 0 in HOLD.
- Gaps in in_valid are allowed and simply stall the index.
- After the edge accepting word 17:
  - operands_valid=1 for exactly HOLD_CYCLES cycles.
  - c_capture=1 in the last of those cycles.
  - in_ready=1 again in the following cycle.
- Minimum frame period: 18 + HOLD_CYCLES cycles.
- A/B never change while operands_valid=1.
- During LOAD_*, A/B are partially updated and must not be used.
- A reset assertion mid-frame or mid-HOLD clears everything immediately (asynchronous). operands_valid and c_capture drop without waiting for a clock.

## Configuration
- MATLOAD_TRANSPOSE_B_EN defined: B words arrive column-major (b00,b10,b01,b11,b02,b12,b03,b13). Stream word 10+m lands in the B slot for row m%2, column m/2. Packing on the B output is still row-major.
- Undefined: B words arrive row-major as described in Operation.
- A ordering and all timing are identical in both builds.

## Test plan
- Reset: assert rst_n=0 mid-frame (after word 7) -> all outputs at reset values with no clock edge. After release, a fresh 18-word frame loads correctly.
- Basic frame: words 1..18 back-to-back -> A=elements 1..10 with A[119:108]=1, B[95:84]=11, B[11:0]=18; operands_valid high 3 cycles; c_capture on the 3rd. With the multiplier attached, C row0 = (1·11+2·15, 1·12+2·16, 1·13+2·17, 1·14+2·18) = (41,44,47,50).
- Backpressure: hold in_valid=1 with new data throughout HOLD -> in_ready=0 and nothing accepted. The first word after HOLD is stored as element 0 of the next frame.
- Gapped input: in_valid toggled 1,0,0,1,… -> same A/B as the back-to-back case. operands_valid rises exactly one cycle after the 18th accept.
- Resync: in_first=1 on the 8th accepted word (value 99) -> frame_err pulses once and A[119:108]=99. operands_valid asserts only after 17 further accepts.
- Transpose build (MATLOAD_TRANSPOSE_B_EN): B stream 11,15,12,16,13,17,14,18 -> B bus identical to the basic-frame case.
